// File: rtl/wb_port_arbiter_if.sv
// Regfile write-port arbitration bus: ALU, rstatus exception and mult/div
// request sides plus the registered regfile write and stall outputs.
interface wb_port_arbiter_if;
  logic        alu_we;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        exc_valid;
  logic [31:0] exc_code;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_exc;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic        stall_req;

  modport master (
    output alu_we, alu_rd, alu_data, exc_valid, exc_code,
           md_valid, md_rd, md_data, md_exc,
    input  md_ready, rf_we, rf_rd, rf_data, stall_req
  );

  modport slave (
    input  alu_we, alu_rd, alu_data, exc_valid, exc_code,
           md_valid, md_rd, md_data, md_exc,
    output md_ready, rf_we, rf_rd, rf_data, stall_req
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter: ALU > pending rstatus write > mult/div FIFO head.
// Optional WB_ARB_STATS_EN adds stat_starved / stat_md_drops counters.
module wb_port_arbiter #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter logic [31:0] MD_EXC_CODE  = 32'd4
) (
  input  logic              clock,
  input  logic              reset,
  wb_port_arbiter_if.slave  bus
`ifdef WB_ARB_STATS_EN
  ,
  output logic [15:0]       stat_starved,
  output logic [7:0]        stat_md_drops
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [3:0]  LIMIT = 4'(STARVE_LIMIT);
  localparam logic [4:0]  RSTATUS = 5'd30;

  typedef struct packed {
    logic        exc;
    logic [4:0]  rd;
    logic [31:0] data;
  } md_entry_t;

  md_entry_t   fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic        exc_pend;
  logic [31:0] exc_code_q;
  logic [3:0]  starve_q;

  logic        alu_win, low_elig, exc_issue, md_issue, enq;
  md_entry_t   head;
  logic        nxt_we;
  logic [4:0]  nxt_rd;
  logic [31:0] nxt_data;
  logic [3:0]  starve_nxt;

  // Ready comes from the registered count only; a same-cycle pop does not help.
  assign bus.md_ready = !reset && (count < CW'(DEPTH));
  assign enq          = bus.md_valid && bus.md_ready;

  always_comb begin
    alu_win    = bus.alu_we && (bus.alu_rd != '0);
    low_elig   = exc_pend || (count != '0);
    exc_issue  = !alu_win && exc_pend;
    md_issue   = !alu_win && !exc_pend && (count != '0);
    head       = fifo_mem[rd_ptr];
    nxt_we     = 1'b0;
    nxt_rd     = '0;
    nxt_data   = '0;
    if (alu_win) begin
      nxt_we   = 1'b1;
      nxt_rd   = bus.alu_rd;
      nxt_data = bus.alu_data;
    end else if (exc_issue) begin
      nxt_we   = 1'b1;
      nxt_rd   = RSTATUS;
      nxt_data = exc_code_q;
    end else if (md_issue) begin
      if (head.exc) begin
        nxt_we   = 1'b1;
        nxt_rd   = RSTATUS;
        nxt_data = MD_EXC_CODE;
      end else begin
        nxt_we   = (head.rd != '0);
        nxt_rd   = head.rd;
        nxt_data = head.data;
      end
    end

    starve_nxt = starve_q;
    if (exc_issue || md_issue)
      starve_nxt = '0;
    else if (alu_win && low_elig && (starve_q != LIMIT))
      starve_nxt = starve_q + 4'd1;
  end

  always_ff @(posedge clock) begin
    if (enq)
      fifo_mem[wr_ptr] <= '{exc: bus.md_exc, rd: bus.md_rd, data: bus.md_data};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.rf_we     <= 1'b0;
      bus.rf_rd     <= '0;
      bus.rf_data   <= '0;
      bus.stall_req <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      exc_pend      <= 1'b0;
      exc_code_q    <= '0;
      starve_q      <= '0;
    end else begin
      bus.rf_we     <= nxt_we;
      bus.rf_rd     <= nxt_rd;
      bus.rf_data   <= nxt_data;
      starve_q      <= starve_nxt;
      bus.stall_req <= (starve_nxt == LIMIT);

      // A new pulse always lands in the pending slot, even while the old one issues.
      if (bus.exc_valid) begin
        exc_pend   <= 1'b1;
        exc_code_q <= bus.exc_code;
      end else if (exc_issue) begin
        exc_pend   <= 1'b0;
      end

      if (enq)      wr_ptr <= wr_ptr + 1'b1;
      if (md_issue) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, md_issue})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef WB_ARB_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_starved  <= '0;
      stat_md_drops <= '0;
    end else begin
      if (alu_win && low_elig && (stat_starved != '1))
        stat_starved <= stat_starved + 16'd1;
      if (md_issue && !head.exc && (head.rd == '0))
        stat_md_drops <= stat_md_drops + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized + directed bench for wb_port_arbiter against a queue-based
// reference model of the write-port priority, latency and starvation rules.
module tb_wb_port_arbiter;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned LIMIT = 4;
  localparam logic [31:0] EXC_CODE = 32'd4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  wb_port_arbiter_if bus ();

`ifdef WB_ARB_STATS_EN
  logic [15:0] stat_starved;
  logic [7:0]  stat_md_drops;
`endif

  wb_port_arbiter #(
    .DEPTH(DEPTH),
    .STARVE_LIMIT(LIMIT),
    .MD_EXC_CODE(EXC_CODE)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
`ifdef WB_ARB_STATS_EN
    ,
    .stat_starved(stat_starved),
    .stat_md_drops(stat_md_drops)
`endif
  );

  typedef struct packed {
    logic        exc;
    logic [4:0]  rd;
    logic [31:0] data;
  } md_t;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  md_t         q[$];
  md_t         md_src[$];
  bit          m_pend;
  logic [31:0] m_code;
  int          m_starve;
  bit          e_we, e_stall;
  logic [4:0]  e_rd;
  logic [31:0] e_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rdy);
    bit  alu_win, low_wait, low_issue;
    md_t h;
    if (reset) begin
      q.delete();
      m_pend = 0; m_code = '0; m_starve = 0;
      e_we = 0; e_rd = '0; e_data = '0; e_stall = 0;
      return;
    end
    alu_win   = bus.alu_we && (bus.alu_rd != 5'd0);
    low_wait  = m_pend || (q.size() > 0);
    low_issue = 0;
    e_we      = 0;
    if (alu_win) begin
      e_we = 1; e_rd = bus.alu_rd; e_data = bus.alu_data;
    end else if (m_pend) begin
      e_we = 1; e_rd = 5'd30; e_data = m_code;
      m_pend = 0; low_issue = 1;
    end else if (q.size() > 0) begin
      h = q.pop_front();
      low_issue = 1;
      if (h.exc) begin
        e_we = 1; e_rd = 5'd30; e_data = EXC_CODE;
      end else if (h.rd != 5'd0) begin
        e_we = 1; e_rd = h.rd; e_data = h.data;
      end
    end
    if (low_issue) m_starve = 0;
    else if (alu_win && low_wait && m_starve < LIMIT) m_starve++;
    e_stall = (m_starve == LIMIT);
    if (bus.exc_valid) begin
      m_pend = 1; m_code = bus.exc_code;
    end
    if (bus.md_valid && rdy)
      q.push_back('{exc: bus.md_exc, rd: bus.md_rd, data: bus.md_data});
  endtask

  task automatic cycle();
    bit rdy, acc;
    if (md_src.size() > 0) begin
      bus.md_valid = 1'b1;
      bus.md_rd    = md_src[0].rd;
      bus.md_data  = md_src[0].data;
      bus.md_exc   = md_src[0].exc;
    end else begin
      bus.md_valid = 1'b0;
      bus.md_rd    = '0;
      bus.md_data  = '0;
      bus.md_exc   = 1'b0;
    end
    #1;
    rdy = !reset && (q.size() < DEPTH);
    check("md_ready", 32'(bus.md_ready), 32'(rdy));
    @(posedge clock);
    acc = bus.md_valid && rdy;
    model_edge(rdy);
    if (acc) void'(md_src.pop_front());
    #1;
    check("rf_we", 32'(bus.rf_we), 32'(e_we));
    check("stall_req", 32'(bus.stall_req), 32'(e_stall));
    if (e_we) begin
      check("rf_rd", 32'(bus.rf_rd), 32'(e_rd));
      check("rf_data", bus.rf_data, e_data);
    end
    if (reset) begin
      check("rst_rd", 32'(bus.rf_rd), 32'd0);
      check("rst_data", bus.rf_data, 32'd0);
    end
    bus.alu_we    = 1'b0;
    bus.exc_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    md_src.delete();
    for (int i = 0; i < n; i++) cycle();
    reset = 1'b0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    bus.alu_we = 1'b1; bus.alu_rd = rd; bus.alu_data = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    bus.alu_we = 0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.exc_valid = 0; bus.exc_code = '0;
    bus.md_valid = 0; bus.md_rd = '0; bus.md_data = '0; bus.md_exc = 0;

    do_reset(2);

    // post-reset ALU write
    alu(5'd5, 32'h1234);
    cycle();
    check("post_rst_rd", 32'(bus.rf_rd), 32'd5);
    check("post_rst_data", bus.rf_data, 32'h1234);
    idle(2);

    // collision: r7, then r30=1, then r9=42
    alu(5'd7, 32'hAA);
    md_src.push_back('{exc: 1'b0, rd: 5'd9, data: 32'd42});
    bus.exc_valid = 1'b1; bus.exc_code = 32'd1;
    cycle();
    cycle();
    check("coll_exc_rd", 32'(bus.rf_rd), 32'd30);
    cycle();
    check("coll_md_data", bus.rf_data, 32'd42);
    idle(2);

    // FIFO full + starvation with ALU held
    for (int k = 0; k < 3; k++)
      md_src.push_back('{exc: 1'b0, rd: 5'(10 + k), data: 32'(100 + k)});
    for (int i = 0; i < 8; i++) begin
      alu(5'd1, 32'(i));
      cycle();
    end
    check("starve_stall", 32'(bus.stall_req), 32'd1);
    idle(6);

    // exception overwrite while ALU busy
    alu(5'd2, 32'h2); bus.exc_valid = 1'b1; bus.exc_code = 32'd1; cycle();
    alu(5'd3, 32'h3); bus.exc_valid = 1'b1; bus.exc_code = 32'd3; cycle();
    idle(4);

    // faulting mult/div and rd=0 drop, with alu_rd=0 not taking the slot
    md_src.push_back('{exc: 1'b1, rd: 5'd12, data: 32'hDEAD});
    md_src.push_back('{exc: 1'b0, rd: 5'd0, data: 32'hBEEF});
    idle(2);
    alu(5'd0, 32'h5555);
    idle(5);

    // reset mid-operation
    for (int k = 0; k < 2; k++)
      md_src.push_back('{exc: 1'b0, rd: 5'(20 + k), data: 32'(k)});
    alu(5'd4, 32'h4); bus.exc_valid = 1'b1; bus.exc_code = 32'h77; cycle();
    alu(5'd4, 32'h5); cycle();
    do_reset(1);
    idle(4);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus.alu_we    = ($urandom_range(0, 99) < 55);
      bus.alu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      bus.alu_data  = $urandom;
      bus.exc_valid = ($urandom_range(0, 9) == 0);
      bus.exc_code  = $urandom;
      if ($urandom_range(0, 9) < 3 && md_src.size() < 3)
        md_src.push_back('{exc: ($urandom_range(0, 7) == 0),
                           rd: ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                           data: $urandom});
      if ($urandom_range(0, 599) == 0) do_reset(1);
      else cycle();
    end
    idle(8);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
